// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the execute stage: multi-cycle MULT/MADD/MSUB, radix-2 restoring
// DIV/DIVU and MTHI/MTLO writes, with a pipeline stall and flush abort.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  output logic        stall_req,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned DIV_STEPS = 32;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_DIV_ITER,
    S_DIV_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [3:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rem_q, quot_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              q_neg_q, r_neg_q, div_zero_q;
  logic [XLEN-1:0]   hi_q, lo_q;

  logic              hi_we, lo_we;
  logic [XLEN-1:0]   hi_d, lo_d;

  logic is_mul_op, is_div_op, accept, last_step;
  assign is_mul_op = (op_i >= OP_MULT) && (op_i <= OP_MSUBU);
  assign is_div_op = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign accept    = (state_q == S_IDLE) && req_i && !flush;
  assign last_step = (cnt_q == CNT_W'(DIV_STEPS - 1));

  // Operand conditioning at accept: DIV works on magnitudes, signs fixed up later
  logic            div_signed;
  logic [XLEN-1:0] dividend_abs, divisor_abs;
  assign div_signed   = (op_i == OP_DIV);
  assign dividend_abs = (div_signed && reg1_i[XLEN-1]) ? XLEN'(-reg1_i) : reg1_i;
  assign divisor_abs  = (div_signed && reg2_i[XLEN-1]) ? XLEN'(-reg2_i) : reg2_i;

  // Product of the latched operands; low 64 bits of a 64x64 multiply give the exact result
  logic              mul_signed;
  logic [2*XLEN-1:0] prod_d;
  assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  always_comb begin
    prod_d = '0;
    if (mul_signed)
      prod_d = {{XLEN{a_q[XLEN-1]}}, a_q} * {{XLEN{b_q[XLEN-1]}}, b_q};
    else
      prod_d = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
  end

  // Accumulate into {HI,LO}; all arithmetic wraps mod 2^64
  logic [2*XLEN-1:0] acc, mac;
  assign acc = {hi_q, lo_q};
  always_comb begin
    mac = prod_q;
    case (op_q)
      OP_MADD, OP_MADDU: mac = acc + prod_q;
      OP_MSUB, OP_MSUBU: mac = acc - prod_q;
      default:           mac = prod_q;
    endcase
  end

  // One restoring divide step: quot_q shifts dividend bits out and quotient bits in
  logic [XLEN:0]   rem_shift;
  logic            rem_ge;
  logic [XLEN-1:0] rem_next, quot_next;
  assign rem_shift = {rem_q, quot_q[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, b_q});
  assign rem_next  = rem_ge ? XLEN'(rem_shift - {1'b0, b_q}) : rem_shift[XLEN-1:0];
  assign quot_next = {quot_q[XLEN-2:0], rem_ge};

  logic [XLEN-1:0] quot_fix, rem_fix;
  assign quot_fix = q_neg_q ? XLEN'(-quot_q) : quot_q;
  assign rem_fix  = r_neg_q ? XLEN'(-rem_q)  : rem_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i && is_mul_op)      state_d = S_MUL1;
          else if (req_i && is_div_op) state_d = S_DIV_ITER;
        end
        S_MUL1:     state_d = S_MUL2;
        S_MUL2:     state_d = S_DONE;
        S_DIV_ITER: if (last_step) state_d = S_DIV_FIX;
        S_DIV_FIX:  state_d = S_DONE;
        S_DONE:     state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Outputs and HI/LO write controls; flush suppresses every write and the stall
  always_comb begin
    stall_req = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (req_i && !flush) begin
          stall_req = is_mul_op || is_div_op;
          if (op_i == OP_MTHI) begin
            hi_we = 1'b1;
            hi_d  = reg1_i;
          end
          if (op_i == OP_MTLO) begin
            lo_we = 1'b1;
            lo_d  = reg1_i;
          end
        end
      end
      S_MUL1, S_DIV_ITER: stall_req = !flush;
      S_MUL2: begin
        stall_req = !flush;
        hi_we     = !flush;
        lo_we     = !flush;
        {hi_d, lo_d} = mac;
      end
      S_DIV_FIX: begin
        stall_req = !flush;
        hi_we     = !flush && !div_zero_q;
        lo_we     = !flush && !div_zero_q;
        hi_d      = rem_fix;
        lo_d      = quot_fix;
      end
      default: stall_req = 1'b0;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  // Architectural HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  // Operand latches, product register and divider iteration state
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      if (accept && is_mul_op) begin
        op_q <= op_i;
        a_q  <= reg1_i;
        b_q  <= reg2_i;
      end
      if (accept && is_div_op) begin
        op_q       <= op_i;
        b_q        <= divisor_abs;
        quot_q     <= dividend_abs;
        rem_q      <= '0;
        cnt_q      <= '0;
        q_neg_q    <= div_signed && (reg1_i[XLEN-1] ^ reg2_i[XLEN-1]);
        r_neg_q    <= div_signed && reg1_i[XLEN-1];
        div_zero_q <= (reg2_i == '0);
      end
      if (state_q == S_MUL1) prod_q <= prod_d;
      if (state_q == S_DIV_ITER) begin
        rem_q  <= rem_next;
        quot_q <= quot_next;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: multiply/accumulate, divide, MT writes,
// flush and reset behaviour against hand-computed HI/LO values and stall lengths.
module tb_hilo_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_i;
  logic [3:0]  op_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        stall_req;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_cmp;
  int n_bad;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  hilo_muldiv_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_i     (req_i),
    .op_i      (op_i),
    .reg1_i    (reg1_i),
    .reg2_i    (reg2_i),
    .stall_req (stall_req),
    .busy_o    (busy_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at the start of a cycle; holds the request while stalled and returns
  // the stall length plus the state seen in the first non-stalled cycle.
  task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cnt, output logic bsy,
                          output logic [31:0] hi_e, output logic [31:0] lo_e);
    bit done;
    req_i  = 1'b1;
    op_i   = op;
    reg1_i = a;
    reg2_i = b;
    cnt    = 0;
    done   = 1'b0;
    bsy    = 1'b0;
    hi_e   = '0;
    lo_e   = '0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (stall_req) begin
        cnt++;
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
        bsy  = busy_o;
        hi_e = hi_o;
        lo_e = lo_o;
      end
    end
    if (!done) check_eq("issue_timeout", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    op_i  = 4'd0;
  endtask

  int          cnt;
  logic        bsy;
  logic [31:0] hi_e, lo_e;

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    req_i  = 1'b0;
    op_i   = 4'd0;
    reg1_i = '0;
    reg2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_stall", 32'(stall_req), 32'd0);
    check_eq("rst_busy",  32'(busy_o),    32'd0);
    check_eq("rst_hi",    hi_o,           32'h0);
    check_eq("rst_lo",    lo_o,           32'h0);
    @(posedge clk);
    #1;

    // MTHI: visible next cycle, no stall
    issue_op(OP_MTHI, 32'h12345678, 32'h0, cnt, bsy, hi_e, lo_e);
    check_eq("mthi_stall", 32'(cnt), 32'd0);
    check_eq("mthi_hi",    hi_o,     32'h12345678);
    check_eq("mthi_busy",  32'(busy_o), 32'd0);

    // MULT -2 * 3 = -6
    issue_op(OP_MULT, 32'hFFFFFFFE, 32'd3, cnt, bsy, hi_e, lo_e);
    check_eq("mult_stall", 32'(cnt), 32'd3);
    check_eq("mult_done_busy", 32'(bsy), 32'd1);
    check_eq("mult_hi", hi_e, 32'hFFFFFFFF);
    check_eq("mult_lo", lo_e, 32'hFFFFFFFA);
    check_eq("mult_idle_busy", 32'(busy_o), 32'd0);

    // MADDU wraps {1,FFFFFFFF} + FFFFFFFE_00000001 to zero
    issue_op(OP_MTHI, 32'h00000001, 32'h0, cnt, bsy, hi_e, lo_e);
    issue_op(OP_MTLO, 32'hFFFFFFFF, 32'h0, cnt, bsy, hi_e, lo_e);
    check_eq("mtlo_lo", lo_o, 32'hFFFFFFFF);
    issue_op(OP_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, cnt, bsy, hi_e, lo_e);
    check_eq("maddu_stall", 32'(cnt), 32'd3);
    check_eq("maddu_hi", hi_e, 32'h0);
    check_eq("maddu_lo", lo_e, 32'h0);
    issue_op(OP_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, cnt, bsy, hi_e, lo_e);
    check_eq("msubu_hi", hi_e, 32'h00000001);
    check_eq("msubu_lo", lo_e, 32'hFFFFFFFF);

    // Signed and unsigned divides
    issue_op(OP_DIV, 32'hFFFFFFF9, 32'd2, cnt, bsy, hi_e, lo_e);
    check_eq("div_neg_stall", 32'(cnt), 32'd34);
    check_eq("div_neg_lo", lo_e, 32'hFFFFFFFD);
    check_eq("div_neg_hi", hi_e, 32'hFFFFFFFF);
    issue_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cnt, bsy, hi_e, lo_e);
    check_eq("div_ovf_lo", lo_e, 32'h80000000);
    check_eq("div_ovf_hi", hi_e, 32'h0);
    issue_op(OP_DIVU, 32'd100, 32'd7, cnt, bsy, hi_e, lo_e);
    check_eq("divu_lo", lo_e, 32'd14);
    check_eq("divu_hi", hi_e, 32'd2);
    issue_op(OP_DIV, 32'd7, 32'hFFFFFFFE, cnt, bsy, hi_e, lo_e);
    check_eq("div_negdiv_lo", lo_e, 32'hFFFFFFFD);
    check_eq("div_negdiv_hi", hi_e, 32'd1);

    // Divide by zero leaves HI/LO alone with full latency
    issue_op(OP_MTHI, 32'h000000AA, 32'h0, cnt, bsy, hi_e, lo_e);
    issue_op(OP_MTLO, 32'h000000BB, 32'h0, cnt, bsy, hi_e, lo_e);
    issue_op(OP_DIVU, 32'h00001234, 32'h0, cnt, bsy, hi_e, lo_e);
    check_eq("divz_stall", 32'(cnt), 32'd34);
    check_eq("divz_hi", hi_e, 32'h000000AA);
    check_eq("divz_lo", lo_e, 32'h000000BB);

    // Flush a divide at T+10, then accept a MULT at T+11
    req_i  = 1'b1;
    op_i   = OP_DIV;
    reg1_i = 32'd100;
    reg2_i = 32'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_div_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_eq("flush_div_busy", 32'(busy_o), 32'd0);
    check_eq("flush_div_hi", hi_o, 32'h000000AA);
    check_eq("flush_div_lo", lo_o, 32'h000000BB);
    issue_op(OP_MULT, 32'd5, 32'd6, cnt, bsy, hi_e, lo_e);
    check_eq("post_flush_stall", 32'(cnt), 32'd3);
    check_eq("post_flush_hi", hi_e, 32'h0);
    check_eq("post_flush_lo", lo_e, 32'd30);

    // Flush in MUL2 suppresses the commit
    req_i  = 1'b1;
    op_i   = OP_MULT;
    reg1_i = 32'd7;
    reg2_i = 32'd7;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_mul2_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_i = 1'b0;
    op_i  = 4'd0;
    check_eq("flush_mul2_busy", 32'(busy_o), 32'd0);
    check_eq("flush_mul2_lo", lo_o, 32'd30);

    // Flushed MTHI does not write
    issue_op(OP_MTHI, 32'h00000055, 32'h0, cnt, bsy, hi_e, lo_e);
    req_i  = 1'b1;
    op_i   = OP_MTHI;
    reg1_i = 32'hDEADBEEF;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_i = 1'b0;
    op_i  = 4'd0;
    check_eq("flush_mthi_hi", hi_o, 32'h00000055);

    // Reset in the middle of a divide
    req_i  = 1'b1;
    op_i   = OP_DIVU;
    reg1_i = 32'd100;
    reg2_i = 32'd7;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check_eq("mid_div_busy", 32'(busy_o), 32'd1);
    rst   = 1'b1;
    req_i = 1'b0;
    op_i  = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_div_busy",  32'(busy_o),    32'd0);
    check_eq("rst_div_stall", 32'(stall_req), 32'd0);
    check_eq("rst_div_hi",    hi_o,           32'h0);
    check_eq("rst_div_lo",    lo_o,           32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
# hilo_muldiv_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the execute stage. It accepts one HI/LO-class operation per request from the EX stage, holds the pipeline through `stall_req` while the operation iterates, and commits the 64-bit result to HI/LO. It also services MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO selection in EX. Flush discards in-flight work without touching architectural state.

## Interface
Parameters: none (32-bit datapath, radix-2 divider fixed).
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  abort in-flight operation; synchronous
- `req_i`  in  1  EX holds a valid HI/LO-class op; stays asserted and stable while `stall_req` is high
- `op_i`  in  4  0 NONE, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 DIV, 8 DIVU, 9 MTHI, 10 MTLO; 11–15 treated as NONE
- `reg1_i`  in  32  rs operand (dividend/multiplicand/MT source)
- `reg2_i`  in  32  rt operand (divisor/multiplier)
- `stall_req`  out  1  hold EX and earlier stages
- `busy_o`  out  1  state != IDLE
- `hi_o`  out  32  architectural HI (registered)
- `lo_o`  out  32  architectural LO (registered)

## Operation
- States: IDLE, MUL1, MUL2, DIV_ITER, DIV_FIX, DONE.
- IDLE, `req_i` & ~`flush`:
  - MULT..MSUBU: latch operands and op → MUL1.
  - DIV/DIVU: latch absolute values (DIV) or raw values (DIVU), quotient/dividend signs, and a divisor-zero flag; clear the 6-bit iteration counter → DIV_ITER.
  - MTHI/MTLO: write `reg1_i` to HI/LO at this edge; stay IDLE.
  - NONE: no action.
- MUL1: register the 64-bit product (signed for MULT/MADD/MSUB, unsigned otherwise) → MUL2.
- MUL2: commit to {HI,LO}: product (MULT/U), {HI,LO}+product (MADD/U), or {HI,LO}−product (MSUB/U). All results wrap mod 2^64 → DONE.
- DIV_ITER: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). Counter increments; after the 32nd step → DIV_FIX.
- DIV_FIX: DIV negates the quotient if the operand signs differ and negates the remainder if the dividend is negative. LO=quotient (truncated toward zero), HI=remainder (sign of dividend). 0x80000000 / −1 yields LO=0x80000000, HI=0. If the divisor-zero flag is set, HI/LO are NOT written; latency is unchanged. → DONE.
- DONE: `req_i` is ignored (it is still the same instruction, now advancing) → IDLE.
- `stall_req` = (IDLE & `req_i` & op ∈ {1..8} & ~`flush`) | state ∈ {MUL1, MUL2, DIV_ITER, DIV_FIX}. It is low in DONE and low for MTHI/MTLO/NONE.
- `flush` in any state: → IDLE at the next edge, no HI/LO write that edge (including MUL2 / DIV_FIX commit and IDLE MTHI/MTLO). `stall_req` is low in the flush cycle.
- `rst` has priority over `flush`. It returns the block to IDLE and sets HI=LO=0, from any state, including mid-divide.

## Timing
- Reset values: `stall_req`=0, `busy_o`=0, `hi_o`=0, `lo_o`=0, state IDLE, counter 0.
- Accept cycle T (IDLE, request seen):
  - Multiply family: `stall_req` high T..T+2; HI/LO updated at the end of T+2 and visible T+3; DONE at T+3 (`stall_req` low); IDLE at T+4.
  - Divide: `stall_req` high T..T+33 (T+1..T+32 iterate, T+33 fix/commit); HI/LO visible T+34; DONE T+34; IDLE T+35.
  - MTHI/MTLO: value visible on `hi_o`/`lo_o` at T+1; no stall.
- The next request is acceptable in the cycle state returns to IDLE. A back-to-back MFHI after a multiply reads the committed value because EX holds it until DONE.
- `busy_o` is high from T+1 through DONE inclusive.

## Test plan
- MULT reg1=0xFFFFFFFE, reg2=3 -> `stall_req` high exactly 3 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+3.
- Preload HI=0x00000001, LO=0xFFFFFFFF via MTHI/MTLO; MADDU 0xFFFFFFFF×0xFFFFFFFF -> HI=0, LO=0 (64-bit wrap); MSUBU same operands from HI=LO=0 -> HI=0x00000001, LO=0xFFFFFFFF.
- DIV −7 / 2 -> `stall_req` high 34 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100/7 -> LO=14, HI=2.
- DIVU 0x1234 / 0 with HI=0xAA, LO=0xBB -> 34-cycle stall, HI=0xAA, LO=0xBB unchanged.
- DIV issued, `flush` at T+10 -> state IDLE at T+11, `stall_req` low at T+10, HI/LO unchanged; MULT presented at T+11 is accepted normally. `flush` during MUL2 -> no commit.
- MTHI 0x12345678 -> `hi_o`=0x12345678 next cycle, `stall_req` never asserted. `rst` asserted mid-divide -> next cycle IDLE, HI=LO=0, `stall_req`=0.
